// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg -- shared definitions for the two-master Wishbone arbiter.
//   arb_state_t     : arbiter state encoding (IDLE / GNT0 / GNT1)
//   DEFAULT_TIMEOUT : default stall limit used when the timeout build is enabled
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_t;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/wb_arb_2.sv
// wb_arb_2 -- arbitrates two Wishbone masters onto one shared RAM port.
//
// Ports
//   clk, rst_n            : clock (rising edge), async active-low reset
//   m0_* / m1_*           : master-side Wishbone requests and responses
//   s_*                   : shared RAM port (request out, s_dat_i/s_ack_i in)
//
// Build option
//   WB_ARB_2_TIMEOUT_EN   : when defined, a stall counter raises a one-cycle
//                           error to the granted master after TIMEOUT cycles
//                           without acknowledge. Undefined: err outputs are 0.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no master owns the RAM port, all s_* outputs driven 0
// GNT0  | master 0 owns the port, held while m0_cyc_i stays high
// GNT1  | master 1 owns the port, held while m1_cyc_i stays high
module wb_arb_2
  import wb_arb_pkg::*;
#(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 16,
  parameter int          SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic                    m0_we_i,
  input  logic [SELECT_WIDTH-1:0] m0_sel_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_cyc_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,

  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic                    m1_we_i,
  input  logic [SELECT_WIDTH-1:0] m1_sel_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_cyc_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,

  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic                    s_we_o,
  output logic [SELECT_WIDTH-1:0] s_sel_o,
  output logic                    s_stb_o,
  output logic                    s_cyc_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i
);

  arb_state_t state, state_nxt;
  logic       last_gnt;   // 0: m0 was granted last, 1: m1 was granted last
  logic       stb_raw;    // granted master's strobe before timeout masking
  logic       err_hit;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last_gnt ? ST_GNT0 : ST_GNT1;
        else if (m0_cyc_i)        state_nxt = ST_GNT0;
        else if (m1_cyc_i)        state_nxt = ST_GNT1;
      end
      // Direct hand-over to the waiting master avoids an IDLE bubble.
      ST_GNT0: if (!m0_cyc_i) state_nxt = m1_cyc_i ? ST_GNT1 : ST_IDLE;
      ST_GNT1: if (!m1_cyc_i) state_nxt = m0_cyc_i ? ST_GNT0 : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      last_gnt <= 1'b1;     // so m0 wins the first tie
    end else begin
      state <= state_nxt;
      if (state_nxt == ST_GNT0 && state != ST_GNT0) last_gnt <= 1'b0;
      else if (state_nxt == ST_GNT1 && state != ST_GNT1) last_gnt <= 1'b1;
    end
  end

  assign stb_raw = (state == ST_GNT0) ? (m0_cyc_i & m0_stb_i) :
                   (state == ST_GNT1) ? (m1_cyc_i & m1_stb_i) : 1'b0;

`ifdef WB_ARB_2_TIMEOUT_EN
  // Counter holds the number of stall cycles already seen; the cycle where
  // it equals TIMEOUT-1 is the TIMEOUT-th stall cycle and raises the error.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] stall_cnt;

  assign err_hit = stb_raw && (stall_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!stb_raw || s_ack_i || err_hit || state_nxt != state) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign err_hit        = 1'b0;
`endif

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_cyc_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      ST_GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_cyc_o  = m0_cyc_i;
        // An ack arriving as cyc drops belongs to no open cycle.
        m0_ack_o = s_ack_i & m0_cyc_i & ~err_hit;
        m0_err_o = err_hit;
      end
      ST_GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_cyc_o  = m1_cyc_i;
        m1_ack_o = s_ack_i & m1_cyc_i & ~err_hit;
        m1_err_o = err_hit;
      end
      default: ;
    endcase
  end

  assign s_stb_o  = stb_raw & ~err_hit;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arb_2.sv
// tb_wb_arb_2 -- self-checking bench for wb_arb_2: directed scenarios plus
// randomized traffic, compared every cycle against an ownership model.
module tb_wb_arb_2;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic m0_we_i, m0_stb_i, m0_cyc_i, m0_ack_o, m0_err_o;
  logic m1_we_i, m1_stb_i, m1_cyc_i, m1_ack_o, m1_err_o;
  logic s_we_o, s_stb_o, s_cyc_o, s_ack_i;

  always #5 clk = ~clk;

  wb_arb_2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  // RAM: either a simple memory acking every strobe, or free-running random responses.
  logic          ram_auto = 1'b0;
  logic          ack_rand = 1'b0;
  logic [DW-1:0] dat_rand = '0;
  logic [DW-1:0] mem [256];

  always_comb begin
    s_ack_i = ram_auto ? (s_cyc_o & s_stb_o) : ack_rand;
    s_dat_i = ram_auto ? mem[s_adr_o[7:0]] : dat_rand;
  end

  always @(posedge clk)
    if (ram_auto && s_cyc_o && s_stb_o && s_we_o) mem[s_adr_o[7:0]] <= s_dat_o;

  // Model: who owns the port (0 none, 1 m0, 2 m1), who won last, stall cycles seen.
  int own = 0;
  int last_m = 1;
  int stall_m = 0;

  function automatic int pick(int o, logic c0, logic c1, int l);
    if (o == 1) return c0 ? 1 : (c1 ? 2 : 0);
    if (o == 2) return c1 ? 2 : (c0 ? 1 : 0);
    if (c0 && c1) return (l == 0) ? 2 : 1;
    return c0 ? 1 : (c1 ? 2 : 0);
  endfunction

  function automatic logic exp_stb_raw();
    if (own == 1) return m0_cyc_i & m0_stb_i;
    if (own == 2) return m1_cyc_i & m1_stb_i;
    return 1'b0;
  endfunction

  function automatic logic exp_err();
`ifdef WB_ARB_2_TIMEOUT_EN
    return exp_stb_raw() && (stall_m == TO - 1);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own = 0;
      last_m = 1;
      stall_m = 0;
    end else begin
      int nx;
      logic sr, e;
      sr = exp_stb_raw();
      e = exp_err();
      nx = pick(own, m0_cyc_i, m1_cyc_i, last_m);
      if (!sr || s_ack_i || e || nx != own) stall_m = 0;
      else stall_m++;
      if (nx != 0 && nx != own) last_m = nx - 1;
      own = nx;
    end
  end

  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      logic e, g0, g1;
      e = exp_err();
      g0 = (own == 1);
      g1 = (own == 2);
      chk("s_cyc", 64'(s_cyc_o), 64'(g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0));
      chk("s_stb", 64'(s_stb_o), 64'(exp_stb_raw() & ~e));
      chk("s_adr", 64'(s_adr_o), 64'(g0 ? m0_adr_i : g1 ? m1_adr_i : '0));
      chk("s_dat", 64'(s_dat_o), 64'(g0 ? m0_dat_i : g1 ? m1_dat_i : '0));
      chk("s_we",  64'(s_we_o),  64'(g0 ? m0_we_i : g1 ? m1_we_i : 1'b0));
      chk("s_sel", 64'(s_sel_o), 64'(g0 ? m0_sel_i : g1 ? m1_sel_i : '0));
      chk("m0_ack", 64'(m0_ack_o), 64'(g0 & m0_cyc_i & s_ack_i & ~e));
      chk("m1_ack", 64'(m1_ack_o), 64'(g1 & m1_cyc_i & s_ack_i & ~e));
      chk("m0_err", 64'(m0_err_o), 64'(g0 & e));
      chk("m1_err", 64'(m1_err_o), 64'(g1 & e));
      chk("m0_dat", 64'(m0_dat_o), 64'(s_dat_i));
      chk("m1_dat", 64'(m1_dat_o), 64'(s_dat_i));
    end
  end

  // Scenario watchers.
  logic watch_lock = 1'b0;
  int   lock_leak = 0;
  logic rec_en = 1'b0;
  int   order[$];

  always @(negedge clk) begin
    if (watch_lock && s_cyc_o && s_adr_o == 16'h0200) lock_leak++;
    if (watch_lock && m1_ack_o) lock_leak++;
    if (rec_en && m0_ack_o) order.push_back(0);
    if (rec_en && m1_ack_o) order.push_back(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = 4'hF;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = 4'hF;
    end
  endtask

  task automatic idle_all();
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
    m0_sel_i = '0;
    m1_sel_i = '0;
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Returns just after the edge that completes the acknowledged beat.
  task automatic wait_ack(input int m, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      logic a;
      #3;
      a = (m == 0) ? m0_ack_o : m1_ack_o;
      @(posedge clk);
      #1;
      if (a) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic alt_master(input int m);
    bit ok;
    for (int k = 0; k < 4; k++) begin
      set_req(m, 1'b1, 1'b1, 1'b0, 16'h0300 + 16'(m), '0);
      wait_ack(m, 40, ok);
      if (!ok) chk($sformatf("alt_m%0d_ack_timeout", m), 64'(ok), 64'd1);
      set_req(m, 1'b0, 1'b0, 1'b0, '0, '0);
      tick();
    end
  endtask

  initial begin
    bit ok;
    logic got, m0a;
    logic [DW-1:0] rd;
    int pulses, first;

    idle_all();
    cmp_en = 1'b1;

    // Reset holds every output at 0 even with both masters requesting and ack high.
    ack_rand = 1'b1;
    set_req(0, 1'b1, 1'b1, 1'b1, 16'h0111, 32'h11111111);
    set_req(1, 1'b1, 1'b1, 1'b1, 16'h0222, 32'h22222222);
    repeat (3) tick();
    #3;
    chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
    chk("rst_s_stb", 64'(s_stb_o), 64'd0);
    chk("rst_s_adr", 64'(s_adr_o), 64'd0);
    chk("rst_acks", 64'({m0_ack_o, m1_ack_o}), 64'd0);
    chk("rst_errs", 64'({m0_err_o, m1_err_o}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    #3;
    chk("first_tie_adr", 64'(s_adr_o), 64'h0111);
    tick();
    ack_rand = 1'b0;

    // m0 writes, m1 reads the same word back.
    do_reset();
    ram_auto = 1'b1;
    set_req(0, 1'b1, 1'b1, 1'b1, 16'h0010, 32'hDEADBEEF);
    wait_ack(0, 10, ok);
    chk("wr_m0_ack", 64'(ok), 64'd1);
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b1, 1'b1, 1'b0, 16'h0010, '0);
    got = 1'b0; m0a = 1'b0; rd = '0;
    for (int i = 0; i < 10 && !got; i++) begin
      #3;
      if (m1_ack_o) begin
        got = 1'b1; rd = m1_dat_o; m0a = m0_ack_o;
      end
      @(posedge clk);
      #1;
    end
    chk("rd_m1_ack", 64'(got), 64'd1);
    chk("rd_m1_dat", 64'(rd), 64'hDEADBEEF);
    chk("rd_m0_no_ack", 64'(m0a), 64'd0);
    idle_all();

    // Simultaneous request after reset: m0 first, then m1 without an IDLE gap.
    do_reset();
    set_req(0, 1'b1, 1'b1, 1'b0, 16'h0100, '0);
    set_req(1, 1'b1, 1'b1, 1'b0, 16'h0200, '0);
    tick();
    #3;
    chk("tie_gnt0_adr", 64'(s_adr_o), 64'h0100);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    #3;
    chk("handover_cyc", 64'(s_cyc_o), 64'd1);
    chk("handover_adr", 64'(s_adr_o), 64'h0200);
    @(posedge clk);
    #1;
    idle_all();

    // m0 locks the bus for four beats while m1 waits.
    do_reset();
    set_req(0, 1'b1, 1'b1, 1'b0, 16'h0100, '0);
    tick();
    set_req(1, 1'b1, 1'b1, 1'b0, 16'h0200, '0);
    watch_lock = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m0_adr_i = 16'h0100 + 16'(b);
      m0_stb_i = 1'b1;
      wait_ack(0, 10, ok);
      chk($sformatf("lock_beat%0d", b), 64'(ok), 64'd1);
      m0_stb_i = 1'b0;
      tick();
    end
    set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
    watch_lock = 1'b0;
    chk("lock_m1_stalled", 64'(lock_leak), 64'd0);
    wait_ack(1, 10, ok);
    chk("lock_m1_after", 64'(ok), 64'd1);
    idle_all();

    // Continuous contention alternates the grant.
    do_reset();
    order.delete();
    rec_en = 1'b1;
    fork
      alt_master(0);
      alt_master(1);
    join
    rec_en = 1'b0;
    chk("alt_count", 64'(order.size()), 64'd8);
    for (int i = 0; i < order.size(); i++)
      chk($sformatf("alt_order%0d", i), 64'(order[i]), 64'(i % 2));
    idle_all();

    // RAM never acknowledges.
    do_reset();
    ram_auto = 1'b0;
    ack_rand = 1'b0;
    set_req(0, 1'b1, 1'b1, 1'b0, 16'h0400, '0);
    tick();
    pulses = 0; first = 0;
    for (int i = 1; i <= 20; i++) begin
      #3;
      if (m0_err_o) begin
        pulses++;
        if (first == 0) first = i;
      end
      @(posedge clk);
      #1;
    end
`ifdef WB_ARB_2_TIMEOUT_EN
    chk("to_pulses", 64'(pulses), 64'd1);
    chk("to_first", 64'(first), 64'd16);
`else
    chk("to_pulses", 64'(pulses), 64'd0);
`endif
    idle_all();

    // Reset during an m1 beat drops the bus at once; tie afterwards goes to m0.
    do_reset();
    set_req(1, 1'b1, 1'b1, 1'b0, 16'h0200, '0);
    tick();
    set_req(0, 1'b1, 1'b1, 1'b0, 16'h0100, '0);
    #2;
    chk("midrst_pre_cyc", 64'(s_cyc_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_cyc", 64'(s_cyc_o), 64'd0);
    chk("midrst_stb", 64'(s_stb_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    #3;
    chk("midrst_tie_adr", 64'(s_adr_o), 64'h0100);
    tick();
    idle_all();

    // Randomized traffic checked by the per-cycle compare.
    ram_auto = 1'b0;
    begin
      int ack_thr, drop_div;
      ack_thr = 8;
      drop_div = 6;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (cyc % 200 == 0) begin
          ack_thr = $urandom_range(0, 2) * 4;
          drop_div = ($urandom_range(0, 1) == 0) ? 6 : 40;
        end
        tick();
        if (m0_cyc_i) m0_cyc_i = ($urandom_range(0, drop_div - 1) != 0);
        else          m0_cyc_i = ($urandom_range(0, 2) == 0);
        if (m1_cyc_i) m1_cyc_i = ($urandom_range(0, drop_div - 1) != 0);
        else          m1_cyc_i = ($urandom_range(0, 2) == 0);
        m0_stb_i = ($urandom_range(0, 3) != 0);
        m1_stb_i = ($urandom_range(0, 3) != 0);
        m0_we_i  = 1'($urandom);
        m1_we_i  = 1'($urandom);
        m0_adr_i = AW'($urandom);
        m1_adr_i = AW'($urandom);
        m0_dat_i = $urandom;
        m1_dat_i = $urandom;
        m0_sel_i = SW'($urandom);
        m1_sel_i = SW'($urandom);
        dat_rand = $urandom;
        ack_rand = ($urandom_range(0, 15) < ack_thr);
        if ($urandom_range(0, 499) == 0) begin
          #1;
          rst_n = 1'b0;
          #1;
          rst_n = 1'b1;
        end
      end
    end
    tick();
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog simulation did not complete t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
